io_controller: RTL

//  Board-side I/O stage between the FPGA pins and the RV32I core's io bus.
//  - Synchronises and debounces IO_WIDTH raw switch/button pins; drives the core's io_input_bus.
//  - Registers the core's io_output_bus onto LEDs.
//  - Time-multiplexes the same value as 3 hex digits on an active-low seven-segment display.

---
 rtl/io_controller_pkg.sv | 49 ++++
 rtl/io_controller_debouncer.sv | 65 ++++++
 rtl/io_controller.sv | 112 +++++++++++
 3 files changed

// File: rtl/io_controller_pkg.sv
// ---------------------------------------------------------------------------
// io_controller_pkg
//   Shared definitions for the board-side I/O stage:
//   - DIGIT_COUNT : number of multiplexed seven-segment digits
//   - digit_idx_t : index of the currently lit digit (value 3 never used)
//   - hex7()      : nibble to active-high {g,f,e,d,c,b,a} glyph
//   - next_digit(): digit index advance 0 -> 1 -> 2 -> 0
// ---------------------------------------------------------------------------
package io_controller_pkg;

    localparam int DIGIT_COUNT = 3;

    typedef enum logic [1:0] {
        DIGIT_0 = 2'd0,
        DIGIT_1 = 2'd1,
        DIGIT_2 = 2'd2
    } digit_idx_t;

    function automatic logic [6:0] hex7(input logic [3:0] nibble);
        hex7 = 7'h00;
        case (nibble)
            4'h0: hex7 = 7'h3F;
            4'h1: hex7 = 7'h06;
            4'h2: hex7 = 7'h5B;
            4'h3: hex7 = 7'h4F;
            4'h4: hex7 = 7'h66;
            4'h5: hex7 = 7'h6D;
            4'h6: hex7 = 7'h7D;
            4'h7: hex7 = 7'h07;
            4'h8: hex7 = 7'h7F;
            4'h9: hex7 = 7'h6F;
            4'hA: hex7 = 7'h77;
            4'hB: hex7 = 7'h7C;
            4'hC: hex7 = 7'h39;
            4'hD: hex7 = 7'h5E;
            4'hE: hex7 = 7'h79;
            4'hF: hex7 = 7'h71;
        endcase
    endfunction

    function automatic digit_idx_t next_digit(input digit_idx_t idx);
        case (idx)
            DIGIT_0: next_digit = DIGIT_1;
            DIGIT_1: next_digit = DIGIT_2;
            default: next_digit = DIGIT_0;
        endcase
    endfunction

endpackage

// File: rtl/io_controller_debouncer.sv
// ---------------------------------------------------------------------------
// io_debouncer
//   One input bit: SYNC_STAGES-deep synchroniser followed by a stability
//   counter. A synced value that differs from the accepted value for
//   DEBOUNCE_CYCLES consecutive cycles becomes the new accepted value; any
//   return to the accepted value restarts the count from zero.
// Ports
//   clock    in  system clock
//   reset    in  asynchronous active-low reset
//   i_pin    in  raw asynchronous pin
//   o_value  out accepted (debounced) value
//   o_accept out high in the cycle before o_value changes, i.e. the new
//                value is loaded on the coming edge
// ---------------------------------------------------------------------------
module io_debouncer
    import io_controller_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clock,
    input  logic reset,
    input  logic i_pin,
    output logic o_value,
    output logic o_accept
);

    localparam int                CNT_W   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_value;
    logic                   w_synced;
    logic                   w_differs;
    logic                   w_accept;

    assign w_synced  = r_sync[SYNC_STAGES-1];
    assign w_differs = (w_synced != r_value);
    assign w_accept  = w_differs && (r_cnt == CNT_MAX);

    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the pre-edge values, which is what makes the sync chain shift.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_sync  <= '0;
            r_cnt   <= '0;
            r_value <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_pin};
            if (!w_differs) begin
                r_cnt <= '0;
            end else if (w_accept) begin
                r_value <= w_synced;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign o_value  = r_value;
    assign o_accept = w_accept;

endmodule

// File: rtl/io_controller.sv
// ---------------------------------------------------------------------------
// io_controller
//   Board-side I/O stage between the FPGA pins and the core's io bus.
// Ports
//   clock          in  system clock, rising edge
//   reset          in  asynchronous active-low reset
//   pin_in         in  raw switch/button pins [IO_WIDTH]
//   io_input_bus   out debounced pins to the core [IO_WIDTH]
//   io_input_event out one-cycle pulse in the cycle io_input_bus changes
//   io_output_bus  in  core output value [IO_WIDTH]
//   led_out        out registered io_output_bus [IO_WIDTH]
//   seg_out        out segments {g,f,e,d,c,b,a}, active-low
//   digit_en       out digit anodes, active-low, bit0 = least significant
// ---------------------------------------------------------------------------
module io_controller
    import io_controller_pkg::*;
#(
    parameter int IO_WIDTH        = 11,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int REFRESH_CYCLES  = 50000
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [IO_WIDTH-1:0] pin_in,
    output logic [IO_WIDTH-1:0] io_input_bus,
    output logic                io_input_event,
    input  logic [IO_WIDTH-1:0] io_output_bus,
    output logic [IO_WIDTH-1:0] led_out,
    output logic [6:0]          seg_out,
    output logic [DIGIT_COUNT-1:0] digit_en
);

    localparam int               REF_W   = $clog2(REFRESH_CYCLES);
    localparam logic [REF_W-1:0] REF_MAX = REF_W'(REFRESH_CYCLES - 1);

    logic [IO_WIDTH-1:0] w_value;
    logic [IO_WIDTH-1:0] w_accept;
    logic [10:0]         w_led_ext;
    logic [3:0]          w_nibble;
    logic [REF_W-1:0]    r_refresh;
    digit_idx_t          r_digit;

    // ---------------- input path ----------------
    for (genvar i = 0; i < IO_WIDTH; i++) begin : g_deb
        io_debouncer #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_deb (
            .clock    (clock),
            .reset    (reset),
            .i_pin    (pin_in[i]),
            .o_value  (w_value[i]),
            .o_accept (w_accept[i])
        );
    end

    assign io_input_bus = w_value;

    // Accept strobes are sampled on the same edge that loads the new bus
    // value, so the pulse coincides with the change and simultaneous bits
    // merge into one pulse.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            io_input_event <= 1'b0;
            led_out        <= '0;
        end else begin
            io_input_event <= |w_accept;
            led_out        <= io_output_bus;
        end
    end

    // ---------------- display path ----------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_refresh <= '0;
            r_digit   <= DIGIT_0;
        end else if (r_refresh == REF_MAX) begin
            r_refresh <= '0;
            r_digit   <= next_digit(r_digit);
        end else begin
            r_refresh <= r_refresh + REF_W'(1);
        end
    end

    // NOTE: every variable written here gets a default first, so no path
    // through the block can leave it unassigned and infer a latch.
    always_comb begin
        w_led_ext = '0;
        for (int b = 0; b < IO_WIDTH && b < 11; b++) begin
            w_led_ext[b] = led_out[b];
        end
        w_nibble = w_led_ext[3:0];
        case (r_digit)
            DIGIT_1: w_nibble = w_led_ext[7:4];
            DIGIT_2: w_nibble = {1'b0, w_led_ext[10:8]};
            default: w_nibble = w_led_ext[3:0];
        endcase
    end

    // Segments and anodes share one register stage so they never disagree.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            seg_out  <= 7'h7F;
            digit_en <= '1;
        end else begin
            seg_out  <= ~hex7(w_nibble);
            digit_en <= ~(DIGIT_COUNT'(1) << r_digit);
        end
    end

endmodule
